// File: rtl/moving_average_pow2.sv
// Boxcar moving average over the last 2^k signed samples, k selectable at run time.
// Exact running sum over a circular buffer, rounded output, optional decimated strobe.
module moving_average_pow2 #(
    parameter int DATA_W       = 16,
    parameter int MAX_LOG2_WIN = 4,
    parameter int WL_W         = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     enable_i,
    input  logic                     data_refresh_i,
    input  logic signed [DATA_W-1:0] din_i,
    input  logic        [WL_W-1:0]   win_log2_i,
    input  logic                     output_refresh_mode_i,
    input  logic                     clear_i,
    output logic signed [DATA_W-1:0] dout_o,
    output logic                     output_pulse_o,
    output logic                     window_full_o
);

    localparam int DEPTH = 1 << MAX_LOG2_WIN;
    localparam int ACC_W = DATA_W + MAX_LOG2_WIN;
    localparam int PTR_W = MAX_LOG2_WIN;
    localparam int CNT_W = MAX_LOG2_WIN + 1;
    localparam logic [WL_W-1:0] MAX_K = WL_W'(MAX_LOG2_WIN);

    logic        [WL_W-1:0]   k_q, k_d;
    logic signed [ACC_W-1:0]  sum_q, sum_d;
    logic        [CNT_W-1:0]  fill_q, fill_d;
    logic        [PTR_W-1:0]  wptr_q, wptr_d;
    logic        [PTR_W-1:0]  dec_q, dec_d;
    logic                     full_q, full_d;
    logic signed [DATA_W-1:0] dout_q, dout_d;
    logic                     pulse_q, pulse_d;

    logic signed [DATA_W-1:0] samples_q [DEPTH];

    logic        [WL_W-1:0]   win_clamped;
    logic                     win_change;
    logic        [WL_W-1:0]   k_eff;
    logic        [CNT_W-1:0]  win_len;
    logic        [PTR_W-1:0]  win_mask;
    logic                     accept;
    logic                     restart;

    logic signed [ACC_W-1:0]  sum_base;
    logic        [CNT_W-1:0]  fill_base;
    logic        [PTR_W-1:0]  wptr_base;
    logic        [PTR_W-1:0]  dec_base;
    logic                     full_base;

    logic signed [ACC_W-1:0]  din_ext;
    logic signed [ACC_W-1:0]  evicted_ext;
    logic signed [ACC_W-1:0]  sum_upd;
    logic        [CNT_W-1:0]  fill_inc;
    logic                     full_upd;
    logic        [PTR_W-1:0]  dec_upd;
    logic                     pulse_upd;
    logic        [ACC_W:0]    rnd;
    logic signed [ACC_W:0]    sum_wide;
    logic signed [DATA_W-1:0] avg;

    always_comb begin
        win_clamped = (win_log2_i > MAX_K) ? MAX_K : win_log2_i;
        win_change  = enable_i && (win_clamped != k_q);
        k_eff       = win_change ? win_clamped : k_q;
        win_len     = CNT_W'(1) << k_eff;
        win_mask    = PTR_W'(win_len - 1'b1);
        accept      = enable_i && data_refresh_i && !clear_i;
        restart     = win_change || clear_i;
    end

    // A restart (clear or new window) behaves as if the stream began this cycle.
    always_comb begin
        sum_base  = restart ? '0 : sum_q;
        fill_base = restart ? '0 : fill_q;
        wptr_base = restart ? '0 : wptr_q;
        dec_base  = restart ? '0 : dec_q;
        full_base = restart ? 1'b0 : full_q;
    end

    always_comb begin
        din_ext     = {{PTR_W{din_i[DATA_W-1]}}, din_i};
        evicted_ext = {{PTR_W{samples_q[wptr_base][DATA_W-1]}}, samples_q[wptr_base]};
        sum_upd     = full_base ? (sum_base + din_ext - evicted_ext)
                                : (sum_base + din_ext);
        fill_inc    = fill_base + 1'b1;
        full_upd    = full_base || (fill_inc == win_len);
        dec_upd     = full_base ? ((dec_base + 1'b1) & win_mask) : '0;
        pulse_upd   = full_upd && (output_refresh_mode_i || (dec_upd == '0));
    end

    // Half an LSB of the shifted result is added before the arithmetic shift:
    // round half toward +inf. With k=0 the offset is zero and dout equals din.
    always_comb begin
        rnd      = (ACC_W+1)'(win_len >> 1);
        sum_wide = $signed({sum_upd[ACC_W-1], sum_upd}) + $signed(rnd);
        avg      = DATA_W'(sum_wide >>> k_eff);
    end

    always_comb begin
        k_d     = k_q;
        sum_d   = sum_q;
        fill_d  = fill_q;
        wptr_d  = wptr_q;
        dec_d   = dec_q;
        full_d  = full_q;
        dout_d  = dout_q;
        pulse_d = 1'b0;
        if (enable_i) begin
            k_d    = k_eff;
            sum_d  = sum_base;
            fill_d = fill_base;
            wptr_d = wptr_base;
            dec_d  = dec_base;
            full_d = full_base;
            if (clear_i) begin
                dout_d = '0;
            end else if (accept) begin
                sum_d   = sum_upd;
                fill_d  = full_base ? fill_base : fill_inc;
                wptr_d  = (wptr_base + 1'b1) & win_mask;
                dec_d   = dec_upd;
                full_d  = full_upd;
                pulse_d = pulse_upd;
                if (pulse_upd) begin
                    dout_d = avg;
                end
            end
        end
    end

    // k resets to the maximum; the first enabled cycle latches the clamped input
    // through the restart path, which leaves the same all-zero state as reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            k_q     <= MAX_K;
            sum_q   <= '0;
            fill_q  <= '0;
            wptr_q  <= '0;
            dec_q   <= '0;
            full_q  <= 1'b0;
            dout_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            k_q     <= k_d;
            sum_q   <= sum_d;
            fill_q  <= fill_d;
            wptr_q  <= wptr_d;
            dec_q   <= dec_d;
            full_q  <= full_d;
            dout_q  <= dout_d;
            pulse_q <= pulse_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            samples_q[wptr_base] <= din_i;
        end
    end

    assign dout_o         = dout_q;
    assign output_pulse_o = pulse_q;
    assign window_full_o  = full_q;

endmodule

// File: tb/tb_moving_average_pow2.sv
// Directed-vector bench for moving_average_pow2: fill, rounding, decimation,
// window change, clear/enable and asynchronous reset.
module tb_moving_average_pow2;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               data_refresh;
    logic signed [15:0] din;
    logic        [2:0]  win_log2;
    logic               mode;
    logic               clear;
    logic signed [15:0] dout;
    logic               pulse;
    logic               full;

    int checks = 0;
    int errors = 0;

    moving_average_pow2 #(.DATA_W(16), .MAX_LOG2_WIN(4), .WL_W(3)) dut (
        .clk_i                 (clk),
        .rst_n_i               (rst_n),
        .enable_i              (enable),
        .data_refresh_i        (data_refresh),
        .din_i                 (din),
        .win_log2_i            (win_log2),
        .output_refresh_mode_i (mode),
        .clear_i               (clear),
        .dout_o                (dout),
        .output_pulse_o        (pulse),
        .window_full_o         (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_sample(input int v);
        data_refresh = 1'b1;
        din = 16'(v);
        @(posedge clk);
        #1;
        data_refresh = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (dout !== 16'sd0) begin errors++; $display("FAIL reset_dout got %0d want 0", dout); end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", pulse); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    endtask

    task automatic test_window4;
        int vals[5] = '{10, 20, 30, 40, 50};
        win_log2 = 3'd2;
        mode = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            do_sample(vals[i]);
            checks++; if (pulse !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL w4_fill%0d got pulse=%b full=%b want 0 0", i, pulse, full); end
        end
        do_sample(vals[3]);
        checks++; if (pulse !== 1'b1 || dout !== 16'sd25 || full !== 1'b1) begin errors++; $display("FAIL w4_first got pulse=%b dout=%0d full=%b want 1 25 1", pulse, dout, full); end
        tick(1);
        checks++; if (pulse !== 1'b0 || dout !== 16'sd25) begin errors++; $display("FAIL w4_idle got pulse=%b dout=%0d want 0 25", pulse, dout); end
        do_sample(vals[4]);
        checks++; if (pulse !== 1'b1 || dout !== 16'sd35) begin errors++; $display("FAIL w4_second got pulse=%b dout=%0d want 1 35", pulse, dout); end
    endtask

    task automatic test_rounding;
        win_log2 = 3'd1;
        tick(1);
        checks++; if (full !== 1'b0 || dout !== 16'sd35) begin errors++; $display("FAIL rnd_restart got full=%b dout=%0d want 0 35", full, dout); end
        do_sample(-3);
        checks++; if (pulse !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL rnd_fill got pulse=%b full=%b want 0 0", pulse, full); end
        do_sample(-2);
        checks++; if (pulse !== 1'b1 || dout !== -16'sd2) begin errors++; $display("FAIL rnd_neg got pulse=%b dout=%0d want 1 -2", pulse, dout); end
        do_sample(32767);
        checks++; if (dout !== 16'sd16383) begin errors++; $display("FAIL rnd_mixed got %0d want 16383", dout); end
        do_sample(32767);
        checks++; if (pulse !== 1'b1 || dout !== 16'sd32767) begin errors++; $display("FAIL rnd_max got pulse=%b dout=%0d want 1 32767", pulse, dout); end
    endtask

    task automatic test_decimation;
        int npulse = 0;
        win_log2 = 3'd3;
        mode = 1'b0;
        tick(1);
        for (int i = 1; i <= 24; i++) begin
            logic exp_p;
            do_sample(8);
            exp_p = (i % 8 == 0);
            if (pulse === 1'b1) npulse++;
            checks++; if (pulse !== exp_p) begin errors++; $display("FAIL dec_pulse%0d got %b want %b", i, pulse, exp_p); end
            if (i == 1) begin
                checks++; if (dout !== 16'sd32767) begin errors++; $display("FAIL dec_hold got %0d want 32767", dout); end
            end
            if (exp_p) begin
                checks++; if (dout !== 16'sd8) begin errors++; $display("FAIL dec_dout%0d got %0d want 8", i, dout); end
            end
        end
        tick(1);
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL dec_width got %b want 0", pulse); end
        checks++; if (npulse !== 3) begin errors++; $display("FAIL dec_count got %0d want 3", npulse); end
    endtask

    task automatic test_window_change;
        mode = 1'b1;
        win_log2 = 3'd2;
        tick(1);
        checks++; if (full !== 1'b0 || dout !== 16'sd8) begin errors++; $display("FAIL wc_restart got full=%b dout=%0d want 0 8", full, dout); end
        for (int v = 1; v <= 4; v++) do_sample(v);
        checks++; if (pulse !== 1'b1 || dout !== 16'sd3) begin errors++; $display("FAIL wc_w4 got pulse=%b dout=%0d want 1 3", pulse, dout); end
        do_sample(5);
        checks++; if (dout !== 16'sd4 || full !== 1'b1) begin errors++; $display("FAIL wc_run got dout=%0d full=%b want 4 1", dout, full); end
        win_log2 = 3'd3;
        do_sample(6);
        checks++; if (full !== 1'b0 || dout !== 16'sd4 || pulse !== 1'b0) begin errors++; $display("FAIL wc_switch got full=%b dout=%0d pulse=%b want 0 4 0", full, dout, pulse); end
        for (int v = 7; v <= 12; v++) begin
            do_sample(v);
            checks++; if (pulse !== 1'b0 || dout !== 16'sd4) begin errors++; $display("FAIL wc_fill%0d got pulse=%b dout=%0d want 0 4", v, pulse, dout); end
        end
        do_sample(13);
        checks++; if (pulse !== 1'b1 || dout !== 16'sd10 || full !== 1'b1) begin errors++; $display("FAIL wc_w8 got pulse=%b dout=%0d full=%b want 1 10 1", pulse, dout, full); end
    endtask

    task automatic test_clear_enable;
        clear = 1'b1;
        do_sample(100);
        clear = 1'b0;
        checks++; if (dout !== 16'sd0 || full !== 1'b0 || pulse !== 1'b0) begin errors++; $display("FAIL clr got dout=%0d full=%b pulse=%b want 0 0 0", dout, full, pulse); end
        for (int i = 0; i < 7; i++) do_sample(16);
        checks++; if (full !== 1'b0 || pulse !== 1'b0) begin errors++; $display("FAIL clr_fill got full=%b pulse=%b want 0 0", full, pulse); end
        do_sample(16);
        checks++; if (full !== 1'b1 || pulse !== 1'b1 || dout !== 16'sd16) begin errors++; $display("FAIL clr_full got full=%b pulse=%b dout=%0d want 1 1 16", full, pulse, dout); end
        enable = 1'b0;
        win_log2 = 3'd1;
        din = 16'sd1000;
        for (int i = 0; i < 4; i++) begin
            data_refresh = (i % 2 == 0);
            clear = (i == 2);
            tick(1);
            checks++; if (pulse !== 1'b0 || dout !== 16'sd16 || full !== 1'b1) begin errors++; $display("FAIL dis%0d got pulse=%b dout=%0d full=%b want 0 16 1", i, pulse, dout, full); end
        end
        data_refresh = 1'b0;
        clear = 1'b0;
        win_log2 = 3'd3;
        enable = 1'b1;
        do_sample(48);
        checks++; if (pulse !== 1'b1 || dout !== 16'sd20) begin errors++; $display("FAIL en_resume got pulse=%b dout=%0d want 1 20", pulse, dout); end
    endtask

    task automatic test_clamp;
        win_log2 = 3'd7;
        tick(1);
        for (int i = 1; i <= 15; i++) do_sample(5);
        checks++; if (full !== 1'b0 || dout !== 16'sd20) begin errors++; $display("FAIL clamp_fill got full=%b dout=%0d want 0 20", full, dout); end
        do_sample(5);
        checks++; if (full !== 1'b1 || pulse !== 1'b1 || dout !== 16'sd5) begin errors++; $display("FAIL clamp_full got full=%b pulse=%b dout=%0d want 1 1 5", full, pulse, dout); end
    endtask

    task automatic test_async_reset;
        win_log2 = 3'd2;
        tick(1);
        do_sample(100);
        do_sample(200);
        checks++; if (dout !== 16'sd5 || full !== 1'b0) begin errors++; $display("FAIL ar_pre got dout=%0d full=%b want 5 0", dout, full); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dout !== 16'sd0 || pulse !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL ar_now got dout=%0d pulse=%b full=%b want 0 0 0", dout, pulse, full); end
        #3 rst_n = 1'b1;
        tick(1);
        do_sample(4);
        do_sample(8);
        do_sample(12);
        checks++; if (full !== 1'b0 || pulse !== 1'b0 || dout !== 16'sd0) begin errors++; $display("FAIL ar_fill got full=%b pulse=%b dout=%0d want 0 0 0", full, pulse, dout); end
        do_sample(16);
        checks++; if (full !== 1'b1 || pulse !== 1'b1 || dout !== 16'sd10) begin errors++; $display("FAIL ar_refill got full=%b pulse=%b dout=%0d want 1 1 10", full, pulse, dout); end
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        data_refresh = 1'b0;
        din = '0;
        win_log2 = 3'd2;
        mode = 1'b1;
        clear = 1'b0;
        #12;
        test_reset();
        #11;
        rst_n = 1'b1;
        enable = 1'b1;
        test_window4();
        test_rounding();
        test_decimation();
        test_window_change();
        test_clear_enable();
        test_clamp();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/moving_average_pow2.md
Name: moving_average_pow2

Overview:
- Parametrised true boxcar moving average; successor to the fixed 16-bit, fixed-mode averager in the ADC sample path.
- Holds the last N samples in a circular buffer, with N = 2^win_log2 selectable at run time up to 2^MAX_LOG2_WIN.
- Sum is exact: add newest sample, subtract the evicted one.
- Adds a fill-state indication, round-half-up output, a synchronous clear, and automatic restart on a window change.

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- MAX_LOG2_WIN, 4: log2 of the largest window; buffer depth is 2^MAX_LOG2_WIN.
- WL_W, 3: width of win_log2; must satisfy 2^WL_W > MAX_LOG2_WIN.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: block enable; when low, all state is frozen.
- data_refresh, in, 1: one-cycle sample strobe; din is valid while it is high.
- din, in, DATA_W: input sample, signed.
- win_log2, in, WL_W: log2 of the window length. Values above MAX_LOG2_WIN are clamped to MAX_LOG2_WIN.
- output_refresh_mode, in, 1: 1 = pulse on every accepted sample once full; 0 = pulse once every N accepted samples (decimating).
- clear, in, 1: synchronous flush of the window.
- dout, out, DATA_W: averaged sample, signed.
- output_pulse, out, 1: one-cycle strobe marking a new dout.
- window_full, out, 1: high once N samples have been accumulated since the last restart.

Behaviour:
- Reset values (asynchronous, rst_n low): dout=0, output_pulse=0, window_full=0. Internally: sum=0, fill count=0, write pointer=0, decimation count=0, latched window = clamp(win_log2). Buffer contents need no reset.
- Accumulator: signed, DATA_W+MAX_LOG2_WIN bits. It cannot overflow.
- Accept condition: a sample is accepted on a clock edge where enable=1, data_refresh=1 and clear=0.
- Accepted sample, window not yet full:
  - buf[wptr] <= din; sum <= sum + din; fill count increments.
- Accepted sample, window full:
  - old = buf[wptr], i.e. the sample written exactly N accepts earlier.
  - sum <= sum + din - old; buf[wptr] <= din.
- Write pointer: wptr increments modulo N and wraps from N-1 to 0.
- window_full: rises on the edge that accepts the Nth sample.
- Output formula, k = latched win_log2:
  - k=0: dout = din.
  - k>0: dout = (sum_next + 2^(k-1)) >>> k, where sum_next is the post-update sum. This is arithmetic shift with round half toward +inf.
  - The result always fits in DATA_W; no saturation logic is needed.
- Latency: dout and output_pulse update on the same edge as the sum, i.e. they are visible in the cycle after data_refresh is sampled high.
- Pulse generation:
  - output_pulse is high for exactly one cycle and only after an accepted sample with window_full (post-update) = 1.
  - Mode 1: pulse on every such sample.
  - Mode 0: pulse when the decimation counter (mod N, counting accepts since the window filled) wraps. The first pulse is on the filling sample, then every N accepts after that.
  - When no pulse is issued, dout holds its previous value.
- Fill phase: no pulses and dout held. With k=0 the window is full after the first accepted sample.
- clear=1 (with enable=1):
  - sum, fill count, wptr, decimation count and window_full go to 0; dout goes to 0; output_pulse=0.
  - A data_refresh in the same cycle is discarded.
- Window change: each cycle with enable=1, clamp(win_log2) is compared with the latched value. On a mismatch:
  - New value is latched.
  - Restart as for clear, except dout is held.
  - A data_refresh in the same cycle is accepted as the first sample of the new window.
- output_refresh_mode: sampled per accept; it may change at any time without a restart.
- enable=0: no state changes, output_pulse=0. data_refresh, clear and win_log2 changes are ignored; a pending window change is applied when enable returns.
- Reset mid-fill or mid-stream: everything returns to reset values immediately, and the next accept starts a fresh fill.

Test Plan:
- Window of 4, mode 1: win_log2=2, feed 10,20,30,40,50.
  - No pulse for the first 3 samples.
  - Pulse with dout=25 after 40 (100/4), then dout=35 after 50 (140/4).
  - window_full rises with the 4th sample.
- Rounding and sign: win_log2=1, feed -3,-2 → dout=-2 (round-half-up of -2.5). Then feed 32767,32767 → dout=32767 with no overflow.
- Decimation: win_log2=3, mode 0, 24 samples of value 8 → exactly 3 pulses (after samples 8, 16, 24), each with dout=8. Pulse width is one cycle.
- Window change mid-stream: running full with win_log2=2, switch to 3 on the same cycle as a refresh.
  - window_full drops and dout holds.
  - The next pulse comes after 7 more accepts, with the average of the 8 newest samples.
- Clear and enable:
  - clear together with data_refresh → sample discarded, dout=0, and a fresh fill of N is required.
  - enable=0 while data_refresh toggles → sum and outputs unchanged, no pulses.
- Async reset mid-fill: assert rst_n low between clock edges → dout, output_pulse and window_full read 0 at once. After release, the window refills from empty with the correct average.
